// File: rtl/instr_encoder.sv
// ============================================================================
// instr_encoder : packs RV32 fields into instruction words, queues them with
//                 their byte addresses for the instruction-memory write port.
// Revision 1.0
// ============================================================================
`default_nettype none

module instr_encoder #(
  parameter int                DEPTH     = 2,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [11:0]       imm12,
  input  logic [19:0]       imm20,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_illegal,
  output logic [7:0]        err_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_NOP    = 7'd0;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_OP     = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_SYSTEM = 7'd115;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              accept;
  logic              push;
  logic              pop;

  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr_cnt;

  // Bit placement mirrors the core decoder so decode(encode(f)) == f.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (opcode)
      OP_OP:
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
        enc_word = {imm12, rs1, funct3, rd, opcode};
      OP_STORE:
        enc_word = {imm12[11:5], rs2, rs1, funct3, imm12[4:0], opcode};
      OP_BRANCH:
        enc_word = {imm12[11], imm12[9:4], rs2, rs1, funct3,
                    imm12[3:0], imm12[10], opcode};
      OP_LUI, OP_AUIPC:
        enc_word = {imm20, rd, opcode};
      OP_JAL:
        enc_word = {imm20[19], imm20[9:0], imm20[10], imm20[18:11], rd, opcode};
      OP_NOP:
        enc_word = '0;
      default:
        enc_legal = 1'b0;
    endcase
  end

  assign in_ready  = (count < CNT_W'(DEPTH)) && !clr;
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && enc_legal;
  assign pop       = out_valid && out_ready;

  // When empty the address port shows where the next word will land.
  assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
  assign out_addr  = out_valid ? addr_mem[rd_ptr]  : addr_cnt;

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= enc_word;
      addr_mem[wr_ptr]  <= addr_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      addr_cnt    <= BASE_ADDR;
      err_illegal <= 1'b0;
      err_count   <= '0;
    end else begin
      err_illegal <= accept && !enc_legal;
      if (accept && !enc_legal && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;

      if (clr) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        addr_cnt  <= BASE_ADDR;
        err_count <= '0;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + PTR_W'(1);
          addr_cnt <= addr_cnt + ADDR_W'(4);
        end
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)
          count <= count + CNT_W'(1);
        else if (pop && !push)
          count <= count - CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// tb_instr_encoder : directed and random checks of instr_encoder against a
//                    queue-based reference model. Revision 1.0
// ============================================================================
`default_nettype none

module tb_instr_encoder;

  localparam int                DEPTH     = 2;
  localparam int                ADDR_W    = 32;
  localparam logic [ADDR_W-1:0] BASE_ADDR = '0;

  logic              clk = 1'b0;
  logic              rst_n, clr, in_valid, in_ready, out_valid, out_ready;
  logic [6:0]        opcode, funct7;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic [11:0]       imm12;
  logic [19:0]       imm20;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err_illegal;
  logic [7:0]        err_count;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm12(imm12), .imm20(imm20), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err_illegal(err_illegal),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
  } ent_t;

  ent_t              q[$];
  logic [ADDR_W-1:0] m_addr;
  int unsigned       m_errs;
  bit                m_pulse;
  bit                last_acc;
  int                n_checks = 0;
  int                n_pass   = 0;

  int unsigned legal_ops[11] = '{0, 3, 19, 23, 35, 51, 55, 99, 103, 111, 115};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit is_legal(input int unsigned op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int unsigned bits(input int unsigned v, input int hi, input int lo);
    return (v >> lo) & ((1 << (hi - lo + 1)) - 1);
  endfunction

  // Instruction word built field by field from the RV32 format tables.
  function automatic logic [31:0] model_enc(input int unsigned op, d, s1, s2, f3, f7, i12, i20);
    int unsigned w;
    int unsigned regs;
    regs = (s2 << 20) + (s1 << 15) + (f3 << 12);
    case (op)
      51:               w = (f7 << 25) + regs + (d << 7) + op;
      3, 19, 103, 115:  w = (i12 << 20) + (s1 << 15) + (f3 << 12) + (d << 7) + op;
      35:               w = (bits(i12, 11, 5) << 25) + regs + (bits(i12, 4, 0) << 7) + op;
      99:               w = (bits(i12, 11, 11) << 31) + (bits(i12, 9, 4) << 25) + regs
                            + (bits(i12, 3, 0) << 8) + (bits(i12, 10, 10) << 7) + op;
      23, 55:           w = (i20 << 12) + (d << 7) + op;
      111:              w = (bits(i20, 19, 19) << 31) + (bits(i20, 9, 0) << 21)
                            + (bits(i20, 10, 10) << 20) + (bits(i20, 18, 11) << 12)
                            + (d << 7) + op;
      default:          w = 0;
    endcase
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    m_addr  = BASE_ADDR;
    m_errs  = 0;
    m_pulse = 1'b0;
  endtask

  // Check every output against the model, then advance the model one clock.
  task automatic cycle();
    bit exp_rdy, exp_vld, pop;
    logic [31:0] ei;
    logic [ADDR_W-1:0] ea;
    #1;
    exp_rdy = (q.size() < DEPTH) && !clr;
    exp_vld = (q.size() != 0);
    ei = exp_vld ? q[0].instr : 32'h0;
    ea = exp_vld ? q[0].addr  : m_addr;
    check("in_ready",    in_ready,    exp_rdy);
    check("out_valid",   out_valid,   exp_vld);
    check("out_instr",   out_instr,   ei);
    check("out_addr",    out_addr,    ea);
    check("err_illegal", err_illegal, m_pulse);
    check("err_count",   err_count,   m_errs);
    last_acc = in_valid && exp_rdy;
    pop      = exp_vld && out_ready;
    m_pulse  = 1'b0;
    if (clr) begin
      q.delete();
      m_addr = BASE_ADDR;
      m_errs = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (last_acc) begin
        if (is_legal(opcode)) begin
          q.push_back('{model_enc(opcode, rd, rs1, rs2, funct3, funct7, imm12, imm20), m_addr});
          m_addr = m_addr + ADDR_W'(4);
        end else begin
          m_pulse = 1'b1;
          if (m_errs < 255) m_errs++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] d, s1, s2,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input logic [11:0] i12, input logic [19:0] i20);
    bit done = 1'b0;
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7;
    imm12 = i12; imm20 = i20; in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      cycle();
      done = last_acc;
    end
    if (!done) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0;
    imm12 = '0; imm20 = '0; last_acc = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_addr",  out_addr,  BASE_ADDR);
    check("rst_err",       {err_illegal, err_count}, 0);
    rst_n = 1'b1;
    cycle();

    // R-type add
    send(7'd51, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'h0, 20'h0);
    check("r_add_instr", out_instr, 32'h002081B3);
    check("r_add_addr",  out_addr,  0);
    do_clr();

    // I then U, second word at +4
    send(7'd19, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'hFFF, 20'h0);
    send(7'd55, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'h0, 20'h12345);
    check("i_instr", out_instr, 32'hFFF00293);
    check("i_addr",  out_addr,  0);
    out_ready = 1'b1;
    cycle();
    check("u_instr", out_instr, 32'h123450B7);
    check("u_addr",  out_addr,  4);
    cycle();
    out_ready = 1'b0;
    do_clr();

    // B and J bit scattering, with decoder round trip
    send(7'd99, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'h800, 20'h0);
    check("b_instr", out_instr, 32'h80000063);
    do_clr();
    send(7'd111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'h0, 20'h00400);
    check("j_instr", out_instr, 32'h0010006F);
    do_clr();
    send(7'd99, 5'd0, 5'd7, 5'd9, 3'd5, 7'd0, 12'hA5C, 20'h0);
    w = out_instr;
    check("b_dec_imm", {w[31], w[7], w[30:25], w[11:8]}, 12'hA5C);
    check("b_dec_rs",  {w[24:20], w[19:15], w[14:12]}, {5'd9, 5'd7, 3'd5});
    do_clr();
    send(7'd111, 5'd13, 5'd0, 5'd0, 3'd0, 7'd0, 12'h0, 20'hB3C96);
    w = out_instr;
    check("j_dec_imm", {w[31], w[19:12], w[20], w[30:21]}, 20'hB3C96);
    check("j_dec_rd",  w[11:7], 5'd13);
    do_clr();

    // Backpressure: two held, third waits, then in-order drain
    send(7'd19, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'h001, 20'h0);
    send(7'd19, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 12'h002, 20'h0);
    opcode = 7'd19; rd = 5'd3; imm12 = 12'h003; in_valid = 1'b1;
    cycle();
    check("bp_full_ready", in_ready, 0);
    cycle();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    out_ready = 1'b0;
    do_clr();

    // Illegal opcode
    send(7'h7F, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 12'h1, 20'h1);
    check("ill_pulse", err_illegal, 1);
    check("ill_count", err_count, 1);
    check("ill_no_valid", out_valid, 0);
    cycle();
    send(7'd19, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'hFFF, 20'h0);
    check("ill_next_addr", out_addr, 0);

    // Async reset with entries held
    send(7'd55, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 12'h0, 20'h1);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("rst_addr_base", out_addr, BASE_ADDR);

    // clr with entries held
    send(7'd23, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 12'h0, 20'h2);
    send(7'd23, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 12'h0, 20'h3);
    do_clr();
    check("clr_valid", out_valid, 0);
    check("clr_addr",  out_addr,  BASE_ADDR);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 7) == 0) opcode = 7'($urandom);
      else                           opcode = 7'(legal_ops[$urandom_range(0, 10)]);
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      funct3 = 3'($urandom); funct7 = 7'($urandom);
      imm12 = 12'($urandom); imm20 = 20'($urandom);
      cycle();
    end
    clr = 1'b0; in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
